// File: rtl/pkt_ram_mc.sv
// rtl/pkt_ram_mc.sv - packet RAM with one write port and a round-robin arbitrated multi-channel read port
module pkt_ram_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_CH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [NUM_CH-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  input  logic                         rsp_ready
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = $clog2(NUM_CH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gnt_idx;
  logic [NUM_CH-1:0]     grant;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  found;
  logic                  stall;
  logic                  accept;

  assign stall = (|rsp_valid) && !rsp_ready;

  // Search begins one past the last granted channel, wrapping around.
  always_comb begin
    found   = 1'b0;
    grant   = '0;
    gnt_idx = ptr;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!found && req_valid[c] && (c == (int'(ptr) + k) % NUM_CH)) begin
          found    = 1'b1;
          grant[c] = 1'b1;
          gnt_idx  = PW'(c);
        end
      end
    end
  end

  assign req_ready = (rst && !stall) ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) rd_addr = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read samples mem before this edge's write lands, so same-address collisions see old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      ptr       <= PW'(NUM_CH - 1);
    end else if (accept) begin
      rsp_valid <= req_ready;
      rsp_data  <= mem[rd_addr];
      ptr       <= gnt_idx;
    end else if (!stall) begin
      rsp_valid <= '0;
    end
  end
endmodule

// File: tb/tb_pkt_ram_mc.sv
// tb/tb_pkt_ram_mc.sv - scoreboard bench for pkt_ram_mc with a round-robin reference model
`timescale 1ns/1ps
module tb_pkt_ram_mc;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NCH = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NCH-1:0] req_valid;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH-1:0] req_ready;
  logic [NCH-1:0] rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready;

  logic        b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [63:0] b_wr_data;
  logic [1:0]  b_req_valid;
  logic [7:0]  b_req_addr;
  logic [1:0]  b_req_ready;
  logic [1:0]  b_rsp_valid;
  logic [63:0] b_rsp_data;
  logic        b_rsp_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NCH-1:0] owner;
    logic [DW-1:0]  data;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] ref_mem [2**AW];
  int m_ptr = NCH - 1;
  bit m_pend = 0;

  pkt_ram_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  pkt_ram_mc #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_CH(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_ready(b_rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round robin: first requesting channel found walking forward from the last winner.
  function automatic int rr_pick(input logic [NCH-1:0] v, input int last);
    for (int s = 1; s <= NCH; s++) begin
      int c;
      c = (last + s) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: evaluated mid-cycle, after the monitor, with inputs stable.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      exp_q.delete();
      m_ptr  = NCH - 1;
      m_pend = 0;
    end else begin
      bit stall_m;
      int g;
      logic [NCH-1:0] exp_rdy;
      logic [AW-1:0]  a;
      exp_t e;
      stall_m = m_pend && !rsp_ready;
      g = stall_m ? -1 : rr_pick(req_valid, m_ptr);
      exp_rdy = (g >= 0) ? NCH'(1 << g) : '0;
      chk("req_ready", req_ready, exp_rdy);
      if (g >= 0) begin
        a = req_addr[g*AW +: AW];
        e.owner = exp_rdy;
        e.data  = ref_mem[a];
        exp_q.push_back(e);
        m_ptr  = g;
        m_pend = 1;
      end else if (!stall_m) begin
        m_pend = 0;
      end
      if (wr_en) ref_mem[wr_addr] = wr_data;
    end
  end

  // Monitor: compares whatever the DUT presents against the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
    end else if (|rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        chk("rsp_owner", rsp_valid, exp_q[0].owner);
        chk("rsp_data", rsp_data, exp_q[0].data);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      chk("missing_rsp", rsp_valid, exp_q[0].owner);
      void'(exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input int a);
    req_addr[ch*AW +: AW] = AW'(a);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    wr_en     = 1'b0;
    rsp_ready = 1'b1;
    repeat (n) cyc();
  endtask

  initial begin
    rst = 1'b0; wr_en = 0; wr_addr = '0; wr_data = '0;
    req_valid = '0; req_addr = '0; rsp_ready = 1'b1;
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
    b_req_valid = '0; b_req_addr = '0; b_rsp_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;

    for (int a = 0; a < 2**AW; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = $urandom;
      cyc();
    end
    idle(2);

    // All four channels request continuously: grants rotate 0,1,2,3,...
    req_valid = 4'hF;
    for (int c = 0; c < NCH; c++) set_addr(c, 10 + c);
    for (int k = 0; k < 8; k++) begin
      #2;
      chk("rr_order", req_ready, 64'(1 << (k % 4)));
      cyc();
    end

    // ch2 response stalled for three cycles while ch1 waits.
    req_valid = 4'b0100; set_addr(2, 20);
    cyc();
    req_valid = 4'b0010; set_addr(1, 21); rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("stall_req_ready", req_ready, 0);
      chk("stall_rsp_valid", rsp_valid, 4'b0100);
      wr_en = 1'b1; wr_addr = AW'(20); wr_data = $urandom;
      cyc();
    end
    wr_en = 1'b0; rsp_ready = 1'b1;
    #2;
    chk("stall_release_grant", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    #2;
    chk("stall_release_rsp", rsp_valid, 4'b0010);
    idle(2);

    // Known value at address 5 read by ch0.
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEADBEEF;
    cyc();
    wr_en = 1'b0; req_valid = 4'b0001; set_addr(0, 5);
    cyc();
    req_valid = '0;
    #2;
    chk("ch0_rsp_valid", rsp_valid, 4'b0001);
    chk("ch0_rsp_data", rsp_data, 32'hDEADBEEF);
    idle(2);

    // Same-cycle write and read of address 7 returns the old word.
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'h1;
    cyc();
    wr_data = 32'h2; req_valid = 4'b1000; set_addr(3, 7);
    cyc();
    wr_en = 1'b0;
    #2;
    chk("collide_old", rsp_data, 32'h1);
    cyc();
    req_valid = '0;
    #2;
    chk("collide_new", rsp_data, 32'h2);
    idle(2);

    // Reset while a ch1 response is stalled.
    req_valid = 4'b0010; set_addr(1, 30);
    cyc();
    req_valid = '0; rsp_ready = 1'b0;
    cyc();
    chk("pre_rst_rsp_valid", rsp_valid, 4'b0010);
    rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    cyc();
    cyc();
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 4'b0011; set_addr(0, 31); set_addr(1, 32);
    #2;
    chk("post_rst_ch0_first", req_ready, 4'b0001);
    cyc();
    idle(2);

    // Randomised traffic on a small address window so writes and reads collide.
    for (int k = 0; k < 2000; k++) begin
      req_valid = NCH'($urandom);
      for (int c = 0; c < NCH; c++) set_addr(c, $urandom_range(0, 15));
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    // Two-channel, 64-bit, 16-deep configuration.
    b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 64'h0123456789ABCDEF;
    cyc();
    b_wr_addr = 4'd3; b_wr_data = 64'hFEDCBA9876543210;
    cyc();
    b_wr_en = 1'b0; b_req_valid = 2'b11; b_req_addr = {4'd3, 4'd15}; b_rsp_ready = 1'b1;
    #2;
    chk("b_grant0", b_req_ready, 2'b01);
    cyc();
    #2;
    chk("b_rsp1_valid", b_rsp_valid, 2'b01);
    chk("b_rsp1_data", b_rsp_data, 64'h0123456789ABCDEF);
    chk("b_grant1", b_req_ready, 2'b10);
    cyc();
    #2;
    chk("b_rsp2_valid", b_rsp_valid, 2'b10);
    chk("b_rsp2_data", b_rsp_data, 64'hFEDCBA9876543210);
    chk("b_grant2", b_req_ready, 2'b01);
    cyc();
    b_req_valid = '0;
    #2;
    chk("b_rsp3_valid", b_rsp_valid, 2'b01);
    chk("b_rsp3_data", b_rsp_data, 64'h0123456789ABCDEF);
    cyc();
    #2;
    chk("b_idle_valid", b_rsp_valid, 2'b00);
    chk("b_idle_data_hold", b_rsp_data, 64'h0123456789ABCDEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
